// File: rtl/tt_harness_pkg.sv
// tt_harness_pkg: shared types and helpers for the tt_vector_harness slice.
//   state_e  - harness sequencer states
//   sat_inc  - saturating increment for counters up to 32 bits wide
package tt_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_APPLY  = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_REPORT = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Increment val, sticking at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/harness_fifo.sv
// harness_fifo: synchronous DEPTH x W FIFO with full/empty flags.
//   clk, rst      clock, synchronous active-high reset (flushes contents)
//   push/push_data write side; accepted when not full, or when full and
//                  popping in the same cycle
//   pop/pop_data  read side; pop_data is the head entry (show-ahead)
//   full/empty    occupancy flags
module harness_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this cycle, so a full FIFO can still take a push.
  assign do_push = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tt_vector_harness.sv
// tt_vector_harness: stimulus/capture engine for tt_um_* user designs.
// Vectors queue over a valid/ready stream, are applied to the DUT pins one at a
// time, settle for vec_wait cycles, then DUT outputs are sampled, compared under
// a mask (uio bits additionally gated by dut_uio_oe) and a verdict is streamed out.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a run (ignored while busy)
//   vec_* / vec_ready        vector input stream
//   dut_ui_in, dut_uio_in    stimulus to DUT (held between vectors)
//   dut_uo_out, dut_uio_out, dut_uio_oe  DUT outputs
//   dut_ena, dut_rst_n       DUT enable and active-low reset
//   res_* / res_ready        verdict output stream
//   busy, done               run status; done pulses one cycle at end of run
//   err_count, vec_count     saturating per-run counters
// Optional: define HARNESS_TRACE_EN to add first_fail_idx / first_fail_obs, which
// capture the 0-based index and observed value of the first failing vector of a run.
module tt_vector_harness
  import tt_harness_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8,
  parameter int IO_W    = 8,
  parameter int DEPTH   = 16,
  parameter int WAIT_W  = 8,
  parameter int RST_CYC = 4,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  vec_valid,
  output logic                  vec_ready,
  input  logic [IN_W+IO_W-1:0]  vec_stim,
  input  logic [OUT_W+IO_W-1:0] vec_exp,
  input  logic [OUT_W+IO_W-1:0] vec_mask,
  input  logic [WAIT_W-1:0]     vec_wait,
  input  logic                  vec_last,
  output logic [IN_W-1:0]       dut_ui_in,
  output logic [IO_W-1:0]       dut_uio_in,
  input  logic [OUT_W-1:0]      dut_uo_out,
  input  logic [IO_W-1:0]       dut_uio_out,
  input  logic [IO_W-1:0]       dut_uio_oe,
  output logic                  dut_ena,
  output logic                  dut_rst_n,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [OUT_W+IO_W-1:0] res_obs,
  output logic                  res_pass,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      vec_count
`ifdef HARNESS_TRACE_EN
  ,
  output logic [CNT_W-1:0]      first_fail_idx,
  output logic [OUT_W+IO_W-1:0] first_fail_obs
`endif
);
  localparam int SW  = IN_W + IO_W;
  localparam int OW  = OUT_W + IO_W;
  localparam int RCW = $clog2(RST_CYC + 1);
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYC - 1);

  typedef struct packed {
    logic              last;
    logic [WAIT_W-1:0] settle;
    logic [OW-1:0]     mask;
    logic [OW-1:0]     exp;
    logic [SW-1:0]     stim;
  } vec_t;

  state_e            state;
  vec_t              fifo_d, fifo_q;
  logic              fifo_full, fifo_empty, pop, push;
  logic [OW-1:0]     cur_exp, cur_mask;
  logic              cur_last;
  logic [WAIT_W-1:0] wait_cnt;
  logic [RCW-1:0]    rst_cnt;
  logic [OW-1:0]     obs, eff_mask;
  logic              pass_now;

  assign fifo_d = '{last: vec_last, settle: vec_wait, mask: vec_mask,
                    exp: vec_exp, stim: vec_stim};

  // Pop only depends on state and occupancy, so vec_ready has no path from vec_valid.
  assign pop       = (state == ST_FETCH) & ~fifo_empty;
  assign vec_ready = ~fifo_full | pop;
  assign push      = vec_valid & vec_ready;

  harness_fifo #(.W($bits(vec_t)), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_d),
    .pop       (pop),
    .pop_data  (fifo_q),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // uio bits the DUT is not driving carry no meaningful value, so they never count.
  assign obs      = {dut_uio_out, dut_uo_out};
  assign eff_mask = cur_mask & {dut_uio_oe, {OUT_W{1'b1}}};
  assign pass_now = ~|((obs ^ cur_exp) & eff_mask);

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign res_valid = (state == ST_REPORT);

`ifdef HARNESS_TRACE_EN
  logic fail_seen;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dut_ui_in  <= '0;
      dut_uio_in <= '0;
      dut_ena    <= 1'b0;
      dut_rst_n  <= 1'b0;
      cur_exp    <= '0;
      cur_mask   <= '0;
      cur_last   <= 1'b0;
      wait_cnt   <= '0;
      rst_cnt    <= '0;
      res_obs    <= '0;
      res_pass   <= 1'b0;
      err_count  <= '0;
      vec_count  <= '0;
`ifdef HARNESS_TRACE_EN
      fail_seen      <= 1'b0;
      first_fail_idx <= '0;
      first_fail_obs <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RESET;
            rst_cnt   <= RST_LOAD;
            // Enable stays up after the run so the DUT state remains observable.
            dut_ena   <= 1'b1;
            dut_rst_n <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
`ifdef HARNESS_TRACE_EN
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            first_fail_obs <= '0;
`endif
          end
        end
        ST_RESET: begin
          if (rst_cnt == '0) begin
            dut_rst_n <= 1'b1;
            state     <= ST_FETCH;
          end else begin
            rst_cnt <= rst_cnt - RCW'(1);
          end
        end
        ST_FETCH: begin
          if (!fifo_empty) begin
            {dut_uio_in, dut_ui_in} <= fifo_q.stim;
            cur_exp  <= fifo_q.exp;
            cur_mask <= fifo_q.mask;
            cur_last <= fifo_q.last;
            wait_cnt <= fifo_q.settle;
            state    <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (wait_cnt == '0) state <= ST_SAMPLE;
          else                wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        ST_SAMPLE: begin
          res_obs  <= obs;
          res_pass <= pass_now;
          state    <= ST_REPORT;
        end
        ST_REPORT: begin
          if (res_ready) begin
            vec_count <= CNT_W'(sat_inc(32'(vec_count), CNT_W));
            if (!res_pass) err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
`ifdef HARNESS_TRACE_EN
            // vec_count before increment is this vector's index within the run.
            if (!res_pass && !fail_seen) begin
              fail_seen      <= 1'b1;
              first_fail_idx <= vec_count;
              first_fail_obs <= res_obs;
            end
`endif
            state <= cur_last ? ST_DONE : ST_FETCH;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_vector_harness.sv
module tb_tt_vector_harness;
  logic        clk = 1'b0;
  logic        rst, start, vec_valid, vec_ready, vec_last, res_valid, res_ready;
  logic [15:0] vec_stim, vec_exp, vec_mask, res_obs;
  logic [7:0]  vec_wait;
  logic [7:0]  dut_ui_in, dut_uio_in, dut_uo_out, dut_uio_out, dut_uio_oe;
  logic        dut_ena, dut_rst_n, res_pass, busy, done;
  logic [15:0] err_count, vec_count;
`ifdef HARNESS_TRACE_EN
  logic [15:0] first_fail_idx, first_fail_obs;
`endif

  // Stand-in user design: uo = ui + 1, uio echoes uio_in, unless overridden.
  logic       ovr_en;
  logic [7:0] ovr_uo, ovr_uio, oe;
  assign dut_uo_out  = ovr_en ? ovr_uo  : dut_ui_in + 8'd1;
  assign dut_uio_out = ovr_en ? ovr_uio : dut_uio_in;
  assign dut_uio_oe  = oe;

  int checks = 0, errors = 0, done_cnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  tt_vector_harness #(.IN_W(8), .OUT_W(8), .IO_W(8), .DEPTH(16), .WAIT_W(8),
                      .RST_CYC(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_stim(vec_stim),
    .vec_exp(vec_exp), .vec_mask(vec_mask), .vec_wait(vec_wait), .vec_last(vec_last),
    .dut_ui_in(dut_ui_in), .dut_uio_in(dut_uio_in), .dut_uo_out(dut_uo_out),
    .dut_uio_out(dut_uio_out), .dut_uio_oe(dut_uio_oe),
    .dut_ena(dut_ena), .dut_rst_n(dut_rst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_obs(res_obs), .res_pass(res_pass),
    .busy(busy), .done(done), .err_count(err_count), .vec_count(vec_count)
`ifdef HARNESS_TRACE_EN
    , .first_fail_idx(first_fail_idx), .first_fail_obs(first_fail_obs)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All tasks are entered just after a negedge.
  task automatic push_vec(input logic [15:0] s, input logic [15:0] e, input logic [15:0] m,
                          input logic [7:0] w, input logic l);
    int n = 0;
    vec_valid = 1'b1; vec_stim = s; vec_exp = e; vec_mask = m; vec_wait = w; vec_last = l;
    while (!vec_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("push_timeout", {31'd0, vec_ready}, 32'd1);
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic get_res(input string tag, input logic [15:0] eobs, input logic epass);
    int n = 0;
    while (!res_valid && n < 500) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_obs"}, {16'd0, res_obs}, {16'd0, eobs});
    chk({tag, "_pass"}, {31'd0, res_pass}, {31'd0, epass});
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; res_ready = 1'b0;
    vec_stim = '0; vec_exp = '0; vec_mask = '0; vec_wait = '0; vec_last = 1'b0;
    ovr_en = 1'b0; ovr_uo = '0; ovr_uio = '0; oe = 8'hFF;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_vec_ready", {31'd0, vec_ready}, 32'd1);
    chk("rst_ui_in",     {24'd0, dut_ui_in}, 32'd0);
    chk("rst_uio_in",    {24'd0, dut_uio_in}, 32'd0);
    chk("rst_ena",       {31'd0, dut_ena}, 32'd0);
    chk("rst_rst_n",     {31'd0, dut_rst_n}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_obs",   {16'd0, res_obs}, 32'd0);
    chk("rst_res_pass",  {31'd0, res_pass}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_done",      {31'd0, done}, 32'd0);
    chk("rst_err",       {16'd0, err_count}, 32'd0);
    chk("rst_vcnt",      {16'd0, vec_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // A: three matching vectors, wait=0
    push_vec(16'h1203, 16'h1204, 16'hFFFF, 8'd0, 1'b0);
    push_vec(16'h3410, 16'h3411, 16'hFFFF, 8'd0, 1'b0);
    push_vec(16'h00FE, 16'h00FF, 16'hFFFF, 8'd0, 1'b1);
    pulse_start();
    chk("a_busy", {31'd0, busy}, 32'd1);
    chk("a_ena",  {31'd0, dut_ena}, 32'd1);
    n = 0;
    while (!dut_rst_n && n < 20) begin n++; @(negedge clk); end
    chk("a_rst_len", n, 32'd4);
    get_res("a0", 16'h1204, 1'b1);
    get_res("a1", 16'h3411, 1'b1);
    get_res("a2", 16'h00FF, 1'b1);
    wait_idle("a");
    chk("a_vcnt", {16'd0, vec_count}, 32'd3);
    chk("a_err",  {16'd0, err_count}, 32'd0);
    chk("a_done", done_cnt, 32'd1);
    chk("a_hold_ui", {24'd0, dut_ui_in}, 32'h00FE);
    chk("a_rst_n", {31'd0, dut_rst_n}, 32'd1);

    // B: mask excludes the one differing bit, then includes it
    ovr_en = 1'b1; ovr_uo = 8'hAB; ovr_uio = 8'h00;
    push_vec(16'h0000, 16'h00AA, 16'h00FE, 8'd0, 1'b0);
    push_vec(16'h0000, 16'h00AA, 16'h00FF, 8'd0, 1'b1);
    pulse_start();
    chk("b_cnt_clr", {16'd0, vec_count}, 32'd0);
    get_res("b0", 16'h00AB, 1'b1);
    get_res("b1", 16'h00AB, 1'b0);
    wait_idle("b");
    chk("b_err",  {16'd0, err_count}, 32'd1);
    chk("b_vcnt", {16'd0, vec_count}, 32'd2);

    // C: uio mismatch ignored when not driven, counted when driven
    ovr_uo = 8'h55; ovr_uio = 8'h3C; oe = 8'h00;
    push_vec(16'h0000, 16'h0055, 16'hFFFF, 8'd0, 1'b1);
    pulse_start();
    get_res("c_oe0", 16'h3C55, 1'b1);
    wait_idle("c0");
    oe = 8'hFF;
    push_vec(16'h0000, 16'h0055, 16'hFFFF, 8'd0, 1'b1);
    pulse_start();
    get_res("c_oeff", 16'h3C55, 1'b0);
    wait_idle("c1");
    chk("c_err", {16'd0, err_count}, 32'd1);

    // D: settle=5 timing and result hold under backpressure
    ovr_en = 1'b0;
    push_vec(16'h005A, 16'h005B, 16'hFFFF, 8'd5, 1'b1);
    pulse_start();
    n = 0;
    while (dut_ui_in != 8'h5A && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (!res_valid && n < 50) begin @(negedge clk); n++; end
    chk("d_latency", n, 32'd7);
    ovr_en = 1'b1; ovr_uo = 8'hEE; ovr_uio = 8'h11;
    repeat (10) @(negedge clk);
    chk("d_hold_valid", {31'd0, res_valid}, 32'd1);
    chk("d_hold_obs",   {16'd0, res_obs}, 32'h005B);
    get_res("d", 16'h005B, 1'b1);
    wait_idle("d");
    ovr_en = 1'b0;

    // E: fill FIFO while idle, then reset mid-APPLY
    for (int i = 0; i < 16; i++) push_vec(16'h0010 + 16'(i), 16'h0000, 16'hFFFF, 8'd20, 1'b1);
    chk("e_full_ready", {31'd0, vec_ready}, 32'd0);
    vec_valid = 1'b1; vec_stim = 16'h00EE;
    repeat (3) @(negedge clk);
    chk("e_17th_ready", {31'd0, vec_ready}, 32'd0);
    vec_valid = 1'b0;
    pulse_start();
    n = 0;
    while (dut_ui_in != 8'h10 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("e_busy",  {31'd0, busy}, 32'd0);
    chk("e_ready", {31'd0, vec_ready}, 32'd1);
    chk("e_ui",    {24'd0, dut_ui_in}, 32'd0);
    push_vec(16'h0077, 16'h0078, 16'hFFFF, 8'd0, 1'b1);
    pulse_start();
    get_res("e_flushed", 16'h0078, 1'b1);
    wait_idle("e");
    chk("e_vcnt", {16'd0, vec_count}, 32'd1);

`ifdef HARNESS_TRACE_EN
    // Trace: vectors 2 and 4 fail
    for (int i = 0; i < 5; i++)
      push_vec(16'(i), (i == 2 || i == 4) ? 16'h00FF : 16'(i + 1), 16'hFFFF, 8'd0, i == 4);
    pulse_start();
    for (int i = 0; i < 5; i++)
      get_res("t", 16'(i + 1), !(i == 2 || i == 4));
    wait_idle("t");
    chk("t_idx", {16'd0, first_fail_idx}, 32'd2);
    chk("t_obs", {16'd0, first_fail_obs}, 32'h0003);
    chk("t_err", {16'd0, err_count}, 32'd2);
    pulse_start();
    chk("t_idx_clr", {16'd0, first_fail_idx}, 32'd0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
